// File: rtl/led_bar_pkg.sv
// Shared types and sizing helpers for the LED bar-graph serializer.
// The FSM enum carries MERGE, which is only reachable when PEAK_HOLD_EN is defined.
package led_bar_pkg;

    localparam int unsigned DEF_N_BANDS       = 8;
    localparam int unsigned DEF_COLUMN_HEIGHT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    function automatic int unsigned total_bits(input int unsigned bands, input int unsigned height);
        return bands * height;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned height);
        return $clog2(height + 1);
    endfunction

endpackage

// File: rtl/led_bar_serializer_peak.sv
// peak_hold_band: per-column peak-dot tracker with frame-count decay.
// Level is derived from the highest set bit, so non-thermometer columns are tolerated.
module peak_hold_band
    import led_bar_pkg::*;
#(
    parameter int unsigned COLUMN_HEIGHT     = DEF_COLUMN_HEIGHT,
    parameter int unsigned PEAK_DECAY_FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     update,
    input  logic [COLUMN_HEIGHT-1:0] col_in,
    input  logic [COLUMN_HEIGHT-1:0] col_frame,
    output logic [COLUMN_HEIGHT-1:0] col_merged
);
    localparam int unsigned LEVEL_W = level_width(COLUMN_HEIGHT);
    localparam int unsigned DECAY_W = idx_width(PEAK_DECAY_FRAMES);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(PEAK_DECAY_FRAMES - 1);

    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] peak;
    logic [DECAY_W-1:0] decay;

    always_comb begin
        level = '0;
        for (int unsigned h = 0; h < COLUMN_HEIGHT; h++) begin
            if (col_in[h]) level = LEVEL_W'(h + 1);
        end
    end

    // Reaching DECAY_LAST here means the incremented count hits PEAK_DECAY_FRAMES.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak  <= '0;
            decay <= '0;
        end else if (update) begin
            if (level >= peak) begin
                peak  <= level;
                decay <= '0;
            end else if (decay == DECAY_LAST) begin
                peak  <= peak - 1'b1;
                decay <= '0;
            end else begin
                decay <= decay + 1'b1;
            end
        end
    end

    always_comb begin
        col_merged = col_frame;
        for (int unsigned h = 0; h < COLUMN_HEIGHT; h++) begin
            if (peak == LEVEL_W'(h + 1)) col_merged[h] = 1'b1;
        end
    end

endmodule

// File: rtl/led_bar_serializer.sv
// led_bar_serializer: captures one bar frame, shifts it MSB first to an LED board, then latches.
// Optional peak-hold dots are enabled with the PEAK_HOLD_EN macro.
module led_bar_serializer
    import led_bar_pkg::*;
#(
    parameter int unsigned N_BANDS           = DEF_N_BANDS,
    parameter int unsigned COLUMN_HEIGHT     = DEF_COLUMN_HEIGHT,
    parameter int unsigned CLK_DIV           = 2,
    parameter int unsigned PEAK_DECAY_FRAMES = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_BANDS*COLUMN_HEIGHT-1:0]   leds,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic                               sclk,
    output logic                               sdata,
    output logic                               latch,
    output logic                               busy,
    output logic                               frame_done
);
    localparam int unsigned TOTAL = total_bits(N_BANDS, COLUMN_HEIGHT);
    localparam int unsigned BIT_W = idx_width(TOTAL);
    localparam int unsigned DIV_W = idx_width(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef PEAK_HOLD_EN
    localparam state_t LOAD_STATE = MERGE;
`else
    localparam state_t LOAD_STATE = SHIFT;
`endif

    state_t           state, state_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [TOTAL-1:0] shadow, shadow_n;
    logic             sclk_n, sdata_n, latch_n, busy_n, done_n, ready_n;
    logic             accept, div_end;

    // frame_ready is raised in the final latch cycle so a waiting frame follows with no gap.
    assign accept  = frame_valid && frame_ready;
    assign div_end = (div_cnt == DIV_LAST);

`ifdef PEAK_HOLD_EN
    logic [TOTAL-1:0] merged;

    for (genvar b = 0; b < N_BANDS; b++) begin : g_band
        peak_hold_band #(
            .COLUMN_HEIGHT     (COLUMN_HEIGHT),
            .PEAK_DECAY_FRAMES (PEAK_DECAY_FRAMES)
        ) u_peak (
            .clk        (clk),
            .rst_n      (rst_n),
            .update     (accept),
            .col_in     (leds[b*COLUMN_HEIGHT +: COLUMN_HEIGHT]),
            .col_frame  (shadow[b*COLUMN_HEIGHT +: COLUMN_HEIGHT]),
            .col_merged (merged[b*COLUMN_HEIGHT +: COLUMN_HEIGHT])
        );
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            shadow      <= '0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_n;
            div_cnt     <= div_n;
            shadow      <= shadow_n;
            sclk        <= sclk_n;
            sdata       <= sdata_n;
            latch       <= latch_n;
            busy        <= busy_n;
            frame_done  <= done_n;
            frame_ready <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        div_n    = div_cnt;
        shadow_n = shadow;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = LOAD_STATE;
                    shadow_n = leds;
                    bit_n    = '0;
                    div_n    = '0;
                end
            end
            MERGE: begin
                state_n = SHIFT;
`ifdef PEAK_HOLD_EN
                shadow_n = merged;
`endif
            end
            SHIFT: begin
                div_n = div_end ? '0 : div_cnt + 1'b1;
                // The current bit always sits in the shadow MSB; advance after the sclk-high half.
                if (div_end && sclk) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_n = LATCH;
                    end else begin
                        bit_n    = bit_cnt + 1'b1;
                        shadow_n = shadow << 1;
                    end
                end
            end
            LATCH: begin
                div_n = div_end ? '0 : div_cnt + 1'b1;
                if (div_end) begin
                    state_n = IDLE;
                    bit_n   = '0;
                    if (accept) begin
                        state_n  = LOAD_STATE;
                        shadow_n = leds;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sclk_n  = 1'b0;
        sdata_n = 1'b0;
        latch_n = (state_n == LATCH);
        busy_n  = (state_n != IDLE);
        done_n  = (state == LATCH) && div_end;
        ready_n = (state_n == IDLE) || ((state_n == LATCH) && (div_n == DIV_LAST));
        if (state_n == SHIFT) begin
            sdata_n = shadow_n[TOTAL-1];
            if (state == SHIFT) sclk_n = div_end ? ~sclk : sclk;
        end
    end

endmodule

// File: tb/tb_led_bar_serializer.sv
// Self-checking bench for led_bar_serializer: per-cycle offset-based reference model,
// MSB-first bit capture on sclk rises, and literal timing/peak expectations.
module tb_led_bar_serializer;
    localparam int unsigned NB    = 8;
    localparam int unsigned H     = 16;
    localparam int unsigned D     = 2;
    localparam int unsigned PDF   = 2;
    localparam int unsigned TOTAL = NB * H;
`ifdef PEAK_HOLD_EN
    localparam int unsigned OFF      = 1;
    localparam int unsigned LATCH_AT = 513;
    localparam int unsigned DONE_AT  = 515;
`else
    localparam int unsigned OFF      = 0;
    localparam int unsigned LATCH_AT = 512;
    localparam int unsigned DONE_AT  = 514;
`endif
    localparam int unsigned L      = 2 * TOTAL * D;
    localparam int unsigned PERIOD = OFF + L + D;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_valid = 1'b0;
    logic [TOTAL-1:0] leds = '0;
    logic             frame_ready, sclk, sdata, latch, busy, frame_done;

    led_bar_serializer #(
        .N_BANDS           (NB),
        .COLUMN_HEIGHT     (H),
        .CLK_DIV           (D),
        .PEAK_DECAY_FRAMES (PDF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .leds        (leds),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sclk        (sclk),
        .sdata       (sdata),
        .latch       (latch),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    bit               m_active = 1'b0;
    int unsigned      m_r = 0;
    bit [TOTAL-1:0]   m_frame = '0;
    bit               e_ready = 1'b0, e_busy = 1'b0, e_sclk = 1'b0;
    bit               e_sdata = 1'b0, e_latch = 1'b0, e_done = 1'b0;
    int unsigned      acc_count = 0;
    int unsigned      acc_q[$];
    int unsigned      acc_hist[$];
    int unsigned      latch_hist[$];
    int unsigned      done_hist[$];
    bit [TOTAL-1:0]   frames_q[$];
    bit               cap[$];
    logic [TOTAL-1:0] last_cap = '0;
`ifdef PEAK_HOLD_EN
    int unsigned      peak[NB];
    int unsigned      dcnt[NB];
`endif

    task automatic chk(input string name, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit [TOTAL-1:0] frame_of(input bit [TOTAL-1:0] f);
        bit [TOTAL-1:0] r;
        r = f;
`ifdef PEAK_HOLD_EN
        for (int unsigned b = 0; b < NB; b++) begin
            int unsigned lvl;
            lvl = 0;
            for (int unsigned h = 0; h < H; h++) if (f[b*H + h]) lvl = h + 1;
            if (lvl >= peak[b]) begin
                peak[b] = lvl;
                dcnt[b] = 0;
            end else begin
                dcnt[b]++;
                if (dcnt[b] == PDF) begin
                    peak[b]--;
                    dcnt[b] = 0;
                end
            end
            if (peak[b] > 0) r[b*H + peak[b] - 1] = 1'b1;
        end
`endif
        return r;
    endfunction

    // Compare current cycle, then advance the model using inputs the DUT samples at the next edge.
    initial begin : compare
        bit prev_sclk, prev_latch;
        prev_sclk  = 1'b0;
        prev_latch = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("frame_ready", frame_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("sclk", sclk, e_sclk);
            chk("sdata", sdata, e_sdata);
            chk("latch", latch, e_latch);
            chk("frame_done", frame_done, e_done);

            if (sclk === 1'b1 && !prev_sclk) cap.push_back(sdata);
            if (latch === 1'b1 && !prev_latch) begin
                latch_hist.push_back(cyc);
                if (acc_q.size() == 0) chk("latch_without_frame", 1, 0);
                else chk("latch_offset", cyc - acc_q[0], LATCH_AT);
            end
            if (frame_done === 1'b1) begin
                done_hist.push_back(cyc);
                if (acc_q.size() == 0) chk("done_without_frame", 1, 0);
                else chk("done_offset", cyc - acc_q.pop_front(), DONE_AT);
            end
            prev_sclk  = (sclk === 1'b1);
            prev_latch = (latch === 1'b1);

            if (e_done) begin
                logic [TOTAL-1:0] v;
                v = '0;
                chk("bit_count", cap.size(), TOTAL);
                for (int unsigned i = 0; i < cap.size() && i < TOTAL; i++) v[TOTAL-1-i] = cap[i];
                last_cap = v;
                if (frames_q.size() == 0) chk("frame_missing", 1, 0);
                else chk("shifted_frame", v, frames_q.pop_front());
                cap.delete();
            end

            if (!rst_n) begin
                m_active = 1'b0;
                {e_ready, e_busy, e_sclk, e_sdata, e_latch, e_done} = '0;
                acc_q.delete();
                frames_q.delete();
                cap.delete();
`ifdef PEAK_HOLD_EN
                for (int unsigned b = 0; b < NB; b++) begin
                    peak[b] = 0;
                    dcnt[b] = 0;
                end
`endif
            end else begin
                bit acc, fin;
                acc = frame_valid && e_ready;
                fin = m_active && (m_r == PERIOD - 1);
                if (acc) begin
                    m_frame = frame_of(leds);
                    frames_q.push_back(m_frame);
                    acc_q.push_back(cyc + 1);
                    acc_hist.push_back(cyc + 1);
                    acc_count++;
                    m_active = 1'b1;
                    m_r = 0;
                end else if (m_active) begin
                    m_r++;
                    if (m_r == PERIOD) m_active = 1'b0;
                end
                e_done = fin;
                {e_ready, e_busy, e_sclk, e_sdata, e_latch} = '0;
                if (!m_active) begin
                    e_ready = 1'b1;
                end else begin
                    e_busy = 1'b1;
                    if (m_r >= OFF && m_r < OFF + L) begin
                        int unsigned s;
                        s = m_r - OFF;
                        e_sclk  = (s % (2 * D)) >= D;
                        e_sdata = m_frame[TOTAL - 1 - s / (2 * D)];
                    end else if (m_r >= OFF + L) begin
                        e_latch = 1'b1;
                        e_ready = (m_r == PERIOD - 1);
                    end
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input string name);
        int unsigned start, t;
        start = acc_count;
        t = 0;
        do begin
            step(1);
            t++;
        end while (acc_count == start && t < 3000);
        chk(name, acc_count != start, 1);
    endtask

    task automatic send(input logic [TOTAL-1:0] f);
        leds = f;
        frame_valid = 1'b1;
        wait_accept("accept_timeout");
        frame_valid = 1'b0;
        leds = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_b2b(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b);
        leds = a;
        frame_valid = 1'b1;
        wait_accept("b2b_accept_a");
        leds = b;
        wait_accept("b2b_accept_b");
        frame_valid = 1'b0;
        leds = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((m_active || e_done) && t < 3000) begin
            step(1);
            t++;
        end
        chk("idle_timeout", m_active, 0);
        step(1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached with errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned n0, l0, d0;
        step(1);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        send(128'h8001_4002_2004_1008_0810_0420_0240_0180);
        wait_idle();
        chk("single_cap", last_cap, 128'h8001_4002_2004_1008_0810_0420_0240_0180);

        n0 = acc_hist.size();
        l0 = latch_hist.size();
        send_b2b({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        wait_idle();
        chk("b2b_accept_gap", acc_hist[n0 + 1] - acc_hist[n0], PERIOD);
        chk("b2b_latch_gap", latch_hist[l0 + 1] - latch_hist[l0], PERIOD);

        send({$urandom, $urandom, $urandom, $urandom});
        n0 = acc_count;
        step(100);
        leds = {$urandom, $urandom, $urandom, $urandom};
        frame_valid = 1'b1;
        step(1);
        frame_valid = 1'b0;
        chk("no_accept_while_busy", acc_count, n0);
        wait_idle();

        send({$urandom, $urandom, $urandom, $urandom});
        step(OFF + 2 * 40 * D);
        rst_n = 1'b0;
        l0 = latch_hist.size();
        d0 = done_hist.size();
        step(2);
        rst_n = 1'b1;
        step(PERIOD + 10);
        chk("abort_no_latch", latch_hist.size(), l0);
        chk("abort_no_done", done_hist.size(), d0);
        send(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        wait_idle();
        chk("after_abort_cap", last_cap, frame_of_noop(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE));

        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                send_b2b({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            else
                send({$urandom, $urandom, $urandom, $urandom});
            wait_idle();
            wait_idle();
        end

`ifdef PEAK_HOLD_EN
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        send({{(TOTAL-16){1'b0}}, 16'h0FFF});
        wait_idle();
        chk("peak_frame1", last_cap[15:0], 16'h0FFF);
        send({{(TOTAL-16){1'b0}}, 16'h0007});
        wait_idle();
        chk("peak_frame2", last_cap[15:0], 16'h0807);
        send({{(TOTAL-16){1'b0}}, 16'h0007});
        wait_idle();
        chk("peak_frame3", last_cap[15:0], 16'h0407);
`endif

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // With peak hold active the merged dots may add bits; without it the frame is shifted verbatim.
    function automatic logic [TOTAL-1:0] frame_of_noop(input logic [TOTAL-1:0] f);
`ifdef PEAK_HOLD_EN
        return last_cap | f;
`else
        return f;
`endif
    endfunction

endmodule

// File: doc/led_bar_serializer.md
Name: led_bar_serializer

Overview:
- Downstream consumer of the spectrum bar-graph vector (N_BANDS columns × COLUMN_HEIGHT thermometer bits).
- Captures one frame via a valid/ready handshake.
- Shifts the frame out serially to a daisy-chained shift-register LED board, then pulses a latch so all LEDs update at once.
- Sits between the band-to-LED converter and the board pins.

Parameters:
- N_BANDS, 8, number of bar columns.
- COLUMN_HEIGHT, 16, LEDs per column.
- CLK_DIV, 2, clk cycles per sclk half-period; must be ≥1.
- PEAK_DECAY_FRAMES, 8, frames a peak dot holds before dropping one level (PEAK_HOLD_EN only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- leds  in  N_BANDS*COLUMN_HEIGHT  bar frame; bit b*COLUMN_HEIGHT+h is band b, row h.
- frame_valid  in  1  leds holds a new frame.
- frame_ready  out  1  block can accept a frame.
- sclk  out  1  shift clock to board.
- sdata  out  1  serial data, stable across each sclk rising edge.
- latch  out  1  storage-register strobe.
- busy  out  1  shift or latch in progress.
- frame_done  out  1  one-cycle pulse when a frame has been latched.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- All outputs are registered.
- Reset values: sclk=0, sdata=0, latch=0, busy=0, frame_done=0, frame_ready=0. The FSM resets to IDLE.
- frame_ready is 1 from the first clk edge with rst_n high.
- Constants: TOTAL = N_BANDS*COLUMN_HEIGHT; D = CLK_DIV.
- FSM states: IDLE → SHIFT → LATCH → IDLE. PEAK_HOLD_EN adds a MERGE state between IDLE and SHIFT.
- IDLE:
  - frame_ready=1.
  - Accept occurs at the edge where frame_valid && frame_ready (edge T0).
  - At accept, leds is copied into a shadow register. Later changes on leds are ignored.
- SHIFT:
  - Bits go out MSB first: leds[TOTAL-1] first, leds[0] last.
  - Bit k occupies cycles [T0+2kD, T0+2(k+1)D).
  - sclk=0 for the first D cycles of each bit and 1 for the second D cycles.
  - sdata changes only on the sclk-low boundary.
  - frame_ready=0, busy=1.
- LATCH:
  - sclk=0, sdata=0, latch=1 for cycles [T0+2·TOTAL·D, T0+2·TOTAL·D+D).
- Return to IDLE at cycle T0+2·TOTAL·D+D: frame_done=1 for exactly one cycle, frame_ready=1, busy=0.
- A frame_valid held high in that cycle is accepted immediately, so back-to-back frames have no idle gap.
- frame_valid while busy: no effect; the upstream holds it.
- Reset mid-operation:
  - Next edge forces reset values.
  - No latch pulse or frame_done is emitted for the aborted frame.
  - Peak state clears.
- Counters:
  - Bit counter width clog2(TOTAL). Divider counter width clog2(D).
  - Terminal counts compare against TOTAL-1 and D-1; there is no wrap-around beyond them.

Optional Feature:
- Macro: PEAK_HOLD_EN.
- Level definition: for each band, level = index of the highest set bit + 1 (0 if none). This is robust to non-thermometer input.
- Per-band state: peak register (clog2(COLUMN_HEIGHT+1) bits) and decay counter.
- Update at accept:
  - If level ≥ peak: peak=level, counter=0.
  - Else: counter++. When counter reaches PEAK_DECAY_FRAMES, peak-1 and counter=0.
- MERGE (one cycle): shadow band |= one-hot(peak-1) if peak>0.
- All SHIFT/LATCH/done timings shift by +1 cycle with the feature enabled.
- Without the macro: no MERGE state, no peak logic; the captured frame is shifted unchanged.

Decomposition:
- Package led_bar_pkg: FSM state enum, TOTAL constant, bit-index and level width constants (clog2-derived).
- Sub-module peak_hold_band (one per band, generate loop, PEAK_HOLD_EN only): level extraction, peak/decay update, merged column output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → all outputs 0; frame_ready=1 one edge after release; no sclk toggles.
- Single frame (defaults, feature off), leds=128'h8001_4002_2004_1008_0810_0420_0240_0180, accepted at T0:
  - 128 bits sampled on sclk rising edges equal leds MSB first.
  - latch=1 in cycles T0+512..513.
  - frame_done=1 at T0+514 only.
- Back-to-back: frame_valid held high with frames A then B → B accepted at T0+514; sclk restarts at T0+514; two latch pulses 514 cycles apart.
- Input change while busy: alter leds and pulse frame_valid at T0+100 → shifted bits equal frame A; no second accept until frame_done.
- Reset mid-shift at bit 40 → sclk/sdata/latch=0 at next edge; no latch pulse or frame_done; new frame after release shifts correctly from bit 0.
- PEAK_HOLD_EN, PEAK_DECAY_FRAMES=2, band 0 levels 12, 3, 3:
  - Frame 1: band-0 bits 0–11.
  - Frame 2: bits 0–2 plus bit 11.
  - Frame 3: bits 0–2 plus bit 10.
  - latch timing is +1 cycle versus feature off.
